// File: rtl/button_event_gen_pkg.sv
// Shared types and default timing for the push-button conditioning chain.
// Defaults assume a 25 MHz system clock.
package button_event_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  localparam int DEF_DEBOUNCE_LIMIT = 250000;    // 10 ms
  localparam int DEF_HOLD_LIMIT     = 12500000;  // 500 ms
  localparam int DEF_REPEAT_LIMIT   = 2500000;   // 100 ms

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_gen_sync_debounce.sv
// Two-flop synchroniser followed by a counting debounce filter.
// o_Rise/o_Fall are combinational: they flag the flip that the next edge commits.
module sync_debounce
  import button_event_gen_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_In,
  output logic o_Level,
  output logic o_Rise,
  output logic o_Fall
);

  localparam int DEB_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [DEB_W-1:0] DEB_END = DEB_W'(DEBOUNCE_LIMIT - 1);

  logic             s1_q;
  logic             s2_q;
  logic             level_q;
  logic             level_d;
  logic [DEB_W-1:0] cnt_q;
  logic [DEB_W-1:0] cnt_d;
  logic             flip;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= i_In;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any sample matching the current level restarts the qualification run.
  always_comb begin
    flip    = (s2_q != level_q) && (cnt_q == DEB_END);
    level_d = level_q;
    cnt_d   = cnt_q;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (flip) begin
      level_d = s2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + DEB_W'(1);
    end
  end

  assign o_Level = level_q;
  assign o_Rise  = flip & s2_q;
  assign o_Fall  = flip & ~s2_q;

endmodule

// File: rtl/button_event_gen.sv
// Push-button event generator: debounced level plus press, release and
// auto-repeat pulses, all registered on the edge the debounced level flips.
module button_event_gen
  import button_event_gen_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
  parameter int HOLD_LIMIT     = DEF_HOLD_LIMIT,
  parameter int REPEAT_LIMIT   = DEF_REPEAT_LIMIT,
  parameter bit REPEAT_EN      = 1'b1
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press_Pulse,
  output logic o_Release_Pulse,
  output logic o_Repeat_Pulse,
  output logic o_Event
);

  localparam int TMR_LIMIT = max_int(HOLD_LIMIT, REPEAT_LIMIT);
  localparam int TMR_W     = (TMR_LIMIT > 1) ? $clog2(TMR_LIMIT) : 1;
  localparam logic [TMR_W-1:0] HOLD_END   = TMR_W'(HOLD_LIMIT - 1);
  localparam logic [TMR_W-1:0] REPEAT_END = TMR_W'(REPEAT_LIMIT - 1);

  state_e           state_q;
  state_e           state_d;
  logic [TMR_W-1:0] tmr_q;
  logic [TMR_W-1:0] tmr_d;
  logic             rise;
  logic             fall;
  logic             press_q;
  logic             press_d;
  logic             release_q;
  logic             release_d;
  logic             repeat_q;
  logic             repeat_d;
  logic             event_q;
  logic             event_d;

  sync_debounce #(
    .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
  ) u_debounce (
    .i_Clk  (i_Clk),
    .i_Rst_L(i_Rst_L),
    .i_In   (i_Switch),
    .o_Level(o_Switch),
    .o_Rise (rise),
    .o_Fall (fall)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Without auto-repeat the hold timer parks at its terminal value.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HOLD;
          tmr_d   = '0;
        end
      end
      ST_HOLD: begin
        if (fall) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else if (tmr_q == HOLD_END) begin
          if (REPEAT_EN) begin
            state_d = ST_REPEAT;
            tmr_d   = '0;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_REPEAT: begin
        if (fall) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else if (tmr_q == REPEAT_END) begin
          tmr_d = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // A release on the same edge as timer expiry suppresses the repeat.
  always_comb begin
    press_d   = (state_q == ST_IDLE) && rise;
    release_d = (state_q != ST_IDLE) && fall;
    repeat_d  = !fall &&
                (((state_q == ST_HOLD) && REPEAT_EN && (tmr_q == HOLD_END)) ||
                 ((state_q == ST_REPEAT) && (tmr_q == REPEAT_END)));
    event_d   = press_d | repeat_d;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      event_q   <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      event_q   <= event_d;
    end
  end

  assign o_Press_Pulse   = press_q;
  assign o_Release_Pulse = release_q;
  assign o_Repeat_Pulse  = repeat_q;
  assign o_Event         = event_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Scoreboard bench: an event-level model of the button behaviour predicts
// pulses per clock edge; a monitor pops and compares what the DUTs emit.
module tb_button_event_gen;

  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;
  localparam int MAXN = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw = 1'b0;

  logic sw_a, pr_a, rl_a, rp_a, ev_a;
  logic sw_b, pr_b, rl_b, rp_b, ev_b;

  button_event_gen #(
    .DEBOUNCE_LIMIT(DEB), .HOLD_LIMIT(HOLD), .REPEAT_LIMIT(REP), .REPEAT_EN(1'b1)
  ) dut_a (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch(sw),
    .o_Switch(sw_a), .o_Press_Pulse(pr_a), .o_Release_Pulse(rl_a),
    .o_Repeat_Pulse(rp_a), .o_Event(ev_a)
  );

  button_event_gen #(
    .DEBOUNCE_LIMIT(DEB), .HOLD_LIMIT(HOLD), .REPEAT_LIMIT(REP), .REPEAT_EN(1'b0)
  ) dut_b (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch(sw),
    .o_Switch(sw_b), .o_Press_Pulse(pr_b), .o_Release_Pulse(rl_b),
    .o_Repeat_Pulse(rp_b), .o_Event(ev_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int cyc;
    int kind;  // 0 press, 1 release, 2 repeat
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  bit   hist[MAXN];
  bit   lvl_exp[MAXN];

  int tests = 0;
  int fails = 0;
  int n = 0;
  int mon_n;
  int exp_events_a = 0, exp_events_b = 0;
  int got_events_a = 0, got_events_b = 0;

  bit m_level = 1'b0;
  int m_last_flip = 0;
  int m_press = -100000;

  function automatic bit samp(input int k);
    return (k < 1) ? 1'b0 : hist[k];
  endfunction

  // Level flips once DEB consecutive synchronised samples (2-edge delay)
  // disagree with it, counting only samples taken after the previous flip.
  task automatic model_edge();
    bit all_diff = 1'b1;
    bit flip, rise, fall;
    exp_t e;
    for (int k = n - 1 - DEB; k <= n - 2; k++)
      if (samp(k) == m_level) all_diff = 1'b0;
    flip = all_diff && ((n - m_last_flip) >= DEB);
    rise = flip && !m_level;
    fall = flip && m_level;
    if (flip) begin
      m_level = !m_level;
      m_last_flip = n;
    end
    lvl_exp[n] = m_level;
    e.cyc = n;
    if (rise) begin
      m_press = n;
      e.kind = 0;
      q_a.push_back(e); q_b.push_back(e);
      exp_events_a++; exp_events_b++;
    end else if (fall) begin
      e.kind = 1;
      q_a.push_back(e); q_b.push_back(e);
    end else if (m_level && (n - m_press) >= HOLD && ((n - m_press - HOLD) % REP) == 0) begin
      e.kind = 2;
      q_a.push_back(e);
      exp_events_a++;
    end
  endtask

  task automatic step(input bit v);
    n++;
    sw = v;
    hist[n] = v;
    model_edge();
    @(negedge clk);
  endtask

  task automatic hold_for(input bit v, input int len);
    for (int i = 0; i < len; i++) step(v);
  endtask

  task automatic model_reset();
    n = 0;
    m_level = 1'b0;
    m_last_flip = 0;
    m_press = -100000;
    q_a.delete();
    q_b.delete();
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mon_n <= 0;
    else        mon_n <= mon_n + 1;
  end

  task automatic check_dut(input int which, input logic lvl, input logic pr,
                           input logic rl, input logic rp, input logic ev);
    string nm;
    int kinds[$];
    exp_t e;
    bit have;
    nm = (which == 0) ? "rep_en" : "no_rep";
    tests++;
    if (lvl !== lvl_exp[mon_n]) begin
      fails++;
      $display("FAIL %s level cyc=%0d got=%0b want=%0b", nm, mon_n, lvl, lvl_exp[mon_n]);
    end
    tests++;
    if (ev !== (pr | rp)) begin
      fails++;
      $display("FAIL %s event_or cyc=%0d got=%0b want=%0b", nm, mon_n, ev, pr | rp);
    end
    tests++;
    if (pr === 1'b1 && rl === 1'b1) begin
      fails++;
      $display("FAIL %s press_and_release cyc=%0d got=both want=at most one", nm, mon_n);
    end
    if (pr === 1'b1) kinds.push_back(0);
    if (rl === 1'b1) kinds.push_back(1);
    if (rp === 1'b1) kinds.push_back(2);
    if (ev === 1'b1) begin
      if (which == 0) got_events_a++; else got_events_b++;
    end
    foreach (kinds[i]) begin
      tests++;
      have = (which == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
      if (!have) begin
        fails++;
        $display("FAIL %s unexpected_pulse cyc=%0d got kind=%0d want none", nm, mon_n, kinds[i]);
      end else begin
        e = (which == 0) ? q_a.pop_front() : q_b.pop_front();
        if (e.kind != kinds[i] || e.cyc != mon_n) begin
          fails++;
          $display("FAIL %s pulse got kind=%0d cyc=%0d want kind=%0d cyc=%0d",
                   nm, kinds[i], mon_n, e.kind, e.cyc);
        end
      end
    end
    forever begin
      have = (which == 0) ? (q_a.size() > 0 && q_a[0].cyc <= mon_n)
                          : (q_b.size() > 0 && q_b[0].cyc <= mon_n);
      if (!have) break;
      e = (which == 0) ? q_a.pop_front() : q_b.pop_front();
      tests++;
      fails++;
      $display("FAIL %s missing_pulse at cyc=%0d got none want kind=%0d cyc=%0d",
               nm, mon_n, e.kind, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_n > 0) begin
      check_dut(0, sw_a, pr_a, rl_a, rp_a, ev_a);
      check_dut(1, sw_b, pr_b, rl_b, rp_b, ev_b);
    end
  end

  task automatic check_zero(input string nm, input logic v);
    tests++;
    if (v !== 1'b0) begin
      fails++;
      $display("FAIL reset_%s got=%0b want=0", nm, v);
    end
  endtask

  task automatic check_all_zero();
    check_zero("sw_a", sw_a); check_zero("press_a", pr_a); check_zero("rel_a", rl_a);
    check_zero("rep_a", rp_a); check_zero("evt_a", ev_a);
    check_zero("sw_b", sw_b); check_zero("press_b", pr_b); check_zero("rel_b", rl_b);
    check_zero("rep_b", rp_b); check_zero("evt_b", ev_b);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero();
    rst_n = 1'b1;
    model_reset();

    // clean press: 8 cycles high
    hold_for(1'b1, 8);
    hold_for(1'b0, 12);
    // bounce: 1,1,1,0 five times never qualifies
    for (int r = 0; r < 5; r++) begin
      hold_for(1'b1, 3);
      hold_for(1'b0, 1);
    end
    hold_for(1'b0, 10);
    // long hold with repeats
    hold_for(1'b1, 40);
    hold_for(1'b0, 12);
    // release lands on the second repeat expiry
    hold_for(1'b1, 13);
    hold_for(1'b0, 12);
    // long hold for the non-repeating instance
    hold_for(1'b1, 30);
    hold_for(1'b0, 12);

    // asynchronous reset mid-hold, switch kept high through reset
    hold_for(1'b1, 10);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    hold_for(1'b1, 10);
    hold_for(1'b0, 12);

    // randomized segments
    for (int s = 0; s < 80; s++) begin
      bit v;
      int len;
      v = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 8);
      hold_for(v, len);
    end
    hold_for(1'b0, 20);

    tests++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      fails++;
      $display("FAIL drain got pending=%0d/%0d want 0/0", q_a.size(), q_b.size());
    end
    tests++;
    if (got_events_a != exp_events_a) begin
      fails++;
      $display("FAIL event_count_rep_en got=%0d want=%0d", got_events_a, exp_events_a);
    end
    tests++;
    if (got_events_b != exp_events_b) begin
      fails++;
      $display("FAIL event_count_no_rep got=%0d want=%0d", got_events_b, exp_events_b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
